// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer.
package muldiv_ctrl_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Divide-by-zero quotient; the remainder slot carries the dividend.
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } md_state_e;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request, multiplier, divider and result signals of the mul/div sequencer.
interface muldiv_ctrl_if;

    logic        i_op_valid;
    logic [1:0]  i_op_type;
    logic [31:0] i_op_a;
    logic [31:0] i_op_b;
    logic        i_flush;
    logic        i_ex_adv;

    logic        o_mul_signed;
    logic [31:0] o_mul_a;
    logic [31:0] o_mul_b;
    logic [63:0] i_mul_result;

    logic        o_div_start;
    logic        o_div_annul;
    logic        o_div_signed;
    logic [31:0] o_div_a;
    logic [31:0] o_div_b;
    logic [63:0] i_div_result;
    logic        i_div_ready;

    logic        o_stallreq;
    logic        o_res_valid;
    logic [31:0] o_res_hi;
    logic [31:0] o_res_lo;

    modport slave (
        input  i_op_valid, i_op_type, i_op_a, i_op_b, i_flush, i_ex_adv,
        input  i_mul_result, i_div_result, i_div_ready,
        output o_mul_signed, o_mul_a, o_mul_b,
        output o_div_start, o_div_annul, o_div_signed, o_div_a, o_div_b,
        output o_stallreq, o_res_valid, o_res_hi, o_res_lo
    );

    modport master (
        output i_op_valid, i_op_type, i_op_a, i_op_b, i_flush, i_ex_adv,
        output i_mul_result, i_div_result, i_div_ready,
        input  o_mul_signed, o_mul_a, o_mul_b,
        input  o_div_start, o_div_annul, o_div_signed, o_div_a, o_div_b,
        input  o_stallreq, o_res_valid, o_res_hi, o_res_lo
    );

endinterface

// File: rtl/muldiv_cnt.sv
// 4-bit loadable down-counter with zero flag; times the multiplier latency.
module muldiv_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic       i_dec,
    input  logic [3:0] i_val,
    output logic       o_zero
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequences one mult/multu/div/divu at a time over the shared multiplier and divider,
// stalling EX while busy and presenting a registered {hi, lo} result.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input logic           clk,
    input logic           rst,
    muldiv_ctrl_if.slave  md_if
);

    localparam logic [3:0] CntInit = 4'(MUL_LAT - 1);

    md_state_e   r_state;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_res_valid;
    logic [31:0] r_res_hi;
    logic [31:0] r_res_lo;

    logic        w_cnt_load;
    logic        w_cnt_zero;

    assign w_cnt_load = (r_state == StIdle) && md_if.i_op_valid && !md_if.i_flush &&
                        !md_if.i_op_type[1];

    muldiv_cnt u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_cnt_load),
        .i_dec  (r_state == StMul),
        .i_val  (CntInit),
        .o_zero (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_op        <= 2'b00;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_res_valid <= 1'b0;
            r_res_hi    <= 32'd0;
            r_res_lo    <= 32'd0;
        end else if (md_if.i_flush) begin
            r_state     <= StIdle;
            r_res_valid <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (md_if.i_op_valid) begin
                        r_op <= md_if.i_op_type;
                        r_a  <= md_if.i_op_a;
                        r_b  <= md_if.i_op_b;
                        unique case (md_if.i_op_type)
                            MD_MULT, MD_MULTU: r_state <= StMul;
                            MD_DIV, MD_DIVU: begin
                                if (md_if.i_op_b == 32'd0) begin
                                    r_state     <= StDone;
                                    r_res_valid <= 1'b1;
                                    r_res_hi    <= md_if.i_op_a;
                                    r_res_lo    <= DIV0_LO;
                                end else begin
                                    r_state <= StDiv;
                                end
                            end
                        endcase
                    end
                end
                StMul: begin
                    if (w_cnt_zero) begin
                        r_state                <= StDone;
                        r_res_valid            <= 1'b1;
                        {r_res_hi, r_res_lo}   <= md_if.i_mul_result;
                    end
                end
                StDiv: begin
                    if (md_if.i_div_ready) begin
                        r_state                <= StDone;
                        r_res_valid            <= 1'b1;
                        {r_res_hi, r_res_lo}   <= md_if.i_div_result;
                    end
                end
                StDone: begin
                    // op_valid is still the same instruction here; only ex_adv releases it.
                    if (md_if.i_ex_adv) begin
                        r_state     <= StIdle;
                        r_res_valid <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        md_if.o_mul_signed = 1'b0;
        md_if.o_mul_a      = 32'd0;
        md_if.o_mul_b      = 32'd0;
        md_if.o_div_start  = 1'b0;
        md_if.o_div_annul  = 1'b0;
        md_if.o_div_signed = 1'b0;
        md_if.o_div_a      = 32'd0;
        md_if.o_div_b      = 32'd0;
        md_if.o_stallreq   = 1'b0;
        unique case (r_state)
            StIdle: md_if.o_stallreq = md_if.i_op_valid && !md_if.i_flush;
            StMul: begin
                md_if.o_stallreq   = !md_if.i_flush;
                md_if.o_mul_signed = (r_op == MD_MULT);
                md_if.o_mul_a      = r_a;
                md_if.o_mul_b      = r_b;
            end
            StDiv: begin
                md_if.o_stallreq   = !md_if.i_flush;
                md_if.o_div_signed = (r_op == MD_DIV);
                md_if.o_div_a      = r_a;
                md_if.o_div_b      = r_b;
                md_if.o_div_start  = !md_if.i_flush && !md_if.i_div_ready;
                md_if.o_div_annul  = md_if.i_flush;
            end
            default: ;
        endcase
    end

    assign md_if.o_res_valid = r_res_valid;
    assign md_if.o_res_hi    = r_res_hi;
    assign md_if.o_res_lo    = r_res_lo;

endmodule
